// File: rtl/time_set_controller_if.sv
// Signal bundle between the time-setting controller and its surroundings:
// registered button levels, current time from the core, and the edited time/commit outputs.
interface time_set_controller_if;
  logic       aumentar;
  logic       disminuir;
  logic       funct_select;
  logic [4:0] hour_in;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic [4:0] hour_out;
  logic [5:0] min_out;
  logic [5:0] sec_out;
  logic [1:0] field;
  logic       config_active;
  logic       write_strobe;

  modport master (
    output aumentar, disminuir, funct_select, hour_in, min_in, sec_in,
    input  hour_out, min_out, sec_out, field, config_active, write_strobe
  );

  modport slave (
    input  aumentar, disminuir, funct_select, hour_in, min_in, sec_in,
    output hour_out, min_out, sec_out, field, config_active, write_strobe
  );
endinterface

// File: rtl/time_set_controller.sv
// Hour/minute/second editing state machine with press edge detection, auto-repeat,
// inactivity abort and a one-cycle commit strobe towards the timekeeping core.
module time_set_controller #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned TIMEOUT      = 500_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  time_set_controller_if.slave bus
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  // Encoding doubles as the field output code.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOUR = 2'd1,
    S_MIN  = 2'd2,
    S_SEC  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_prev_au;
  logic             r_prev_dis;
  logic             r_prev_fs;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_on;
  logic [TO_W-1:0]  r_to_cnt;
  logic [4:0]       r_hour;
  logic [5:0]       r_min;
  logic [5:0]       r_sec;
  logic             r_strobe;

  logic       w_press_au;
  logic       w_press_dis;
  logic       w_press_fs;
  logic       w_any_press;
  logic       w_cfg;
  logic       w_one_held;
  logic       w_rpt_tick;
  logic       w_step_up;
  logic       w_step_dn;
  logic       w_timeout;
  logic       w_snapshot;
  logic       w_strobe_next;
  logic [4:0] w_hour_next;
  logic [5:0] w_min_next;
  logic [5:0] w_sec_next;

  assign w_press_au  = bus.aumentar     & ~r_prev_au;
  assign w_press_dis = bus.disminuir    & ~r_prev_dis;
  assign w_press_fs  = bus.funct_select & ~r_prev_fs;
  assign w_any_press = w_press_au | w_press_dis | w_press_fs;
  assign w_cfg       = (r_state != S_IDLE);
  assign w_one_held  = bus.aumentar ^ bus.disminuir;

  // First tick after the initial hold delay, then one per repeat period.
  assign w_rpt_tick = w_cfg & w_one_held & ~w_press_au & ~w_press_dis &
                      (r_rpt_on ? (r_rpt_cnt == RPT_W'(REPEAT_RATE - 1))
                                : (r_rpt_cnt == RPT_W'(REPEAT_DELAY - 1)));

  // A field-advance press in the same cycle swallows any step.
  assign w_step_up = w_cfg & ~w_press_fs &
                     ((w_press_au & ~bus.disminuir) | (w_rpt_tick & bus.aumentar));
  assign w_step_dn = w_cfg & ~w_press_fs &
                     ((w_press_dis & ~bus.aumentar) | (w_rpt_tick & bus.disminuir));

  assign w_timeout = w_cfg & ~w_any_press & ~w_rpt_tick &
                     (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next  = r_state;
    w_snapshot    = 1'b0;
    w_strobe_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press_fs) begin
          w_state_next = S_HOUR;
          w_snapshot   = 1'b1;
        end
      end
      S_HOUR: begin
        if (w_press_fs)     w_state_next = S_MIN;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_MIN: begin
        if (w_press_fs)     w_state_next = S_SEC;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_SEC: begin
        if (w_press_fs) begin
          w_state_next  = S_IDLE;
          w_strobe_next = 1'b1;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_hour_next = r_hour;
    w_min_next  = r_min;
    w_sec_next  = r_sec;
    if (w_snapshot) begin
      w_hour_next = (bus.hour_in > 5'd23) ? 5'd0 : bus.hour_in;
      w_min_next  = (bus.min_in  > 6'd59) ? 6'd0 : bus.min_in;
      w_sec_next  = (bus.sec_in  > 6'd59) ? 6'd0 : bus.sec_in;
    end else if (w_step_up) begin
      case (r_state)
        S_HOUR:  w_hour_next = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        S_MIN:   w_min_next  = (r_min  == 6'd59) ? 6'd0 : r_min  + 6'd1;
        S_SEC:   w_sec_next  = (r_sec  == 6'd59) ? 6'd0 : r_sec  + 6'd1;
        default: ;
      endcase
    end else if (w_step_dn) begin
      case (r_state)
        S_HOUR:  w_hour_next = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
        S_MIN:   w_min_next  = (r_min  == 6'd0) ? 6'd59 : r_min  - 6'd1;
        S_SEC:   w_sec_next  = (r_sec  == 6'd0) ? 6'd59 : r_sec  - 6'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_au  <= 1'b0;
      r_prev_dis <= 1'b0;
      r_prev_fs  <= 1'b0;
      r_rpt_cnt  <= '0;
      r_rpt_on   <= 1'b0;
      r_to_cnt   <= '0;
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_prev_au  <= bus.aumentar;
      r_prev_dis <= bus.disminuir;
      r_prev_fs  <= bus.funct_select;
      r_hour     <= w_hour_next;
      r_min      <= w_min_next;
      r_sec      <= w_sec_next;
      r_strobe   <= w_strobe_next;

      if (w_rpt_tick) begin
        r_rpt_cnt <= '0;
        r_rpt_on  <= 1'b1;
      end else if (!w_cfg || !w_one_held || w_press_au || w_press_dis) begin
        r_rpt_cnt <= '0;
        r_rpt_on  <= 1'b0;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + 1'b1;
      end

      // Any activity or state entry restarts the inactivity window.
      if (w_state_next == S_IDLE || w_state_next != r_state || w_any_press || w_rpt_tick) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign bus.hour_out      = r_hour;
  assign bus.min_out       = r_min;
  assign bus.sec_out       = r_sec;
  assign bus.field         = r_state;
  assign bus.config_active = w_cfg;
  assign bus.write_strobe  = r_strobe;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed walk through the editing flow, then random
// button activity checked every cycle against an age/idle-count reference model.
module tb_time_set_controller;
  localparam int DELAY = 4;
  localparam int RATE  = 2;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  time_set_controller_if bus();

  time_set_controller #(
    .REPEAT_DELAY(DELAY),
    .REPEAT_RATE (RATE),
    .TIMEOUT     (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc_no = 0;

  // Reference state: field index 0..3, edited values, previous button levels,
  // how long one button has been held alone, and how long the editor has been idle.
  int m_state;
  int m_val[3];
  int lim[3] = '{24, 60, 60};
  bit m_strobe;
  bit m_pau, m_pdis, m_pfs;
  int m_age, m_idle;
  int hin, mi, si;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_no);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_val = '{0, 0, 0};
    m_strobe = 0;
    m_pau = 0; m_pdis = 0; m_pfs = 0;
    m_age = 0; m_idle = 0;
  endtask

  task automatic model_edge(input bit au, input bit dis, input bit fs);
    bit pa, pd, pf, cfg, tick;
    int d;
    pa = au && !m_pau;
    pd = dis && !m_pdis;
    pf = fs && !m_pfs;
    cfg = (m_state != 0);
    tick = 0;
    m_strobe = 0;
    if (cfg && (au ^ dis) && !pa && !pd) begin
      m_age++;
      tick = (m_age >= DELAY) && (((m_age - DELAY) % RATE) == 0);
    end else begin
      m_age = 0;
    end
    if (cfg && !pf) begin
      d = 0;
      if ((pa && !dis) || (tick && au)) d = 1;
      else if ((pd && !au) || (tick && dis)) d = -1;
      if (d != 0) m_val[m_state-1] = (m_val[m_state-1] + d + lim[m_state-1]) % lim[m_state-1];
    end
    if (pf) begin
      if (m_state == 0) begin
        m_val[0] = (hin > 23) ? 0 : hin;
        m_val[1] = (mi > 59) ? 0 : mi;
        m_val[2] = (si > 59) ? 0 : si;
      end
      if (m_state == 3) m_strobe = 1;
      m_state = (m_state + 1) % 4;
      m_idle = 0;
    end else if (cfg) begin
      if (pa || pd || tick) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle >= TMO) begin
          m_state = 0;
          m_idle = 0;
        end
      end
    end else begin
      m_idle = 0;
    end
    m_pau = au; m_pdis = dis; m_pfs = fs;
  endtask

  task automatic check_all();
    chk("hour_out", 32'(bus.hour_out), 32'(m_val[0]));
    chk("min_out", 32'(bus.min_out), 32'(m_val[1]));
    chk("sec_out", 32'(bus.sec_out), 32'(m_val[2]));
    chk("field", 32'(bus.field), 32'(m_state));
    chk("config_active", 32'(bus.config_active), 32'(m_state != 0));
    chk("write_strobe", 32'(bus.write_strobe), 32'(m_strobe));
  endtask

  task automatic cyc(input bit au, input bit dis, input bit fs);
    bus.aumentar = au;
    bus.disminuir = dis;
    bus.funct_select = fs;
    bus.hour_in = 5'(hin);
    bus.min_in = 6'(mi);
    bus.sec_in = 6'(si);
    @(posedge clk);
    model_edge(au, dis, fs);
    #1;
    cyc_no++;
    check_all();
    $display("cyc %0d au=%0b dis=%0b fs=%0b -> field=%0d h=%0d m=%0d s=%0d cfg=%0b strobe=%0b",
             cyc_no, au, dis, fs, bus.field, bus.hour_out, bus.min_out, bus.sec_out,
             bus.config_active, bus.write_strobe);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock.
  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    $display("reset asserted at cycle %0d -> field=%0d h=%0d m=%0d s=%0d", cyc_no,
             bus.field, bus.hour_out, bus.min_out, bus.sec_out);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit au, dis, fs;
    model_reset();
    hin = 0; mi = 0; si = 0;
    bus.aumentar = 0; bus.disminuir = 0; bus.funct_select = 0;
    bus.hour_in = 0; bus.min_in = 0; bus.sec_in = 0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    // Snapshot on entering hour edit.
    hin = 22; mi = 5; si = 7;
    cyc(0, 0, 1);
    chk("snap_field", 32'(bus.field), 1);
    chk("snap_hour", 32'(bus.hour_out), 22);
    chk("snap_min", 32'(bus.min_out), 5);
    chk("snap_sec", 32'(bus.sec_out), 7);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("hour_23", 32'(bus.hour_out), 23);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("hour_wrap_0", 32'(bus.hour_out), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    cyc(0, 1, 0);
    chk("min_wrap_59", 32'(bus.min_out), 59);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    // Held increment: press step, then repeat at 4, 6, 8, 10 edges after the press.
    for (int i = 0; i <= 10; i++) begin
      cyc(1, 0, 0);
      chk("repeat_sec", 32'(bus.sec_out), 32'(11 + ((i >= DELAY) ? (i - DELAY) / RATE + 1 : 0)));
    end
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("commit_strobe", 32'(bus.write_strobe), 1);
    chk("commit_field", 32'(bus.field), 0);
    cyc(0, 0, 0);
    chk("strobe_one_cycle", 32'(bus.write_strobe), 0);
    chk("hold_sec", 32'(bus.sec_out), 15);

    // Inactivity abort from minute edit.
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < TMO; i++) begin
      cyc(0, 0, 0);
      chk("timeout_cfg", 32'(bus.config_active), (i == TMO - 1) ? 0 : 1);
      chk("timeout_no_strobe", 32'(bus.write_strobe), 0);
    end

    // Simultaneous inputs.
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("both_no_step", 32'(bus.hour_out), 22);
    cyc(0, 0, 0);
    cyc(1, 0, 1);
    chk("fs_wins_field", 32'(bus.field), 2);
    chk("fs_wins_hour", 32'(bus.hour_out), 22);
    cyc(0, 0, 0);
    do_reset();
    chk("reset_field", 32'(bus.field), 0);
    chk("reset_min", 32'(bus.min_out), 0);

    // Random phase.
    au = 0; dis = 0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(3) == 0) au = ~au;
      if ($urandom_range(3) == 0) dis = ~dis;
      fs = ($urandom_range(4) == 0);
      if ($urandom_range(15) == 0) begin
        hin = $urandom_range(31);
        mi = $urandom_range(63);
        si = $urandom_range(63);
      end
      cyc(au, dis, fs);
      if ($urandom_range(299) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/time_set_controller.md
# time_set_controller

Time-setting controller that sits downstream of the universal button register. It interprets the registered aumentar, disminuir and funct_select levels as edge-detected presses with auto-repeat, and sequences the hour, minute and second fields through a configuration state machine. When configuration completes, it commits the edited values to the timekeeping core with a one-cycle write strobe.

## Interface
- REPEAT_DELAY, 50_000_000: cycles an inc/dec button must be held before auto-repeat starts (≥2).
- REPEAT_RATE, 10_000_000: cycles between auto-repeat steps (≥1).
- TIMEOUT, 500_000_000: idle cycles in a config state before aborting (≥2).
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- aumentar  input  1  increment button level, already registered upstream.
- disminuir  input  1  decrement button level, already registered upstream.
- funct_select  input  1  field-advance button level, already registered upstream.
- hour_in  input  5  current hour from the timekeeping core, binary.
- min_in  input  6  current minute, binary.
- sec_in  input  6  current second, binary.
- hour_out  output  5  edited hour, 0..23.
- min_out  output  6  edited minute, 0..59.
- sec_out  output  6  edited second, 0..59.
- field  output  2  selected field: 0 = none, 1 = hour, 2 = minute, 3 = second.
- config_active  output  1  high in every config state.
- write_strobe  output  1  one-cycle commit pulse.

## Operation
- Edge detect:
  - Per button, press = level & ~prev, where prev is the level registered on the previous edge.
  - prev resets to 0, so a button held through reset release produces a press on the first edge.
- FSM states: IDLE, SET_HOUR, SET_MIN, SET_SEC.
- funct_select press transitions:
  - IDLE→SET_HOUR: snapshot hour_in/min_in/sec_in into the outputs. Any out-of-range input is clamped to 0.
  - SET_HOUR→SET_MIN, SET_MIN→SET_SEC: no side effects.
  - SET_SEC→IDLE: pulse write_strobe.
- Step events:
  - Apply only in config states, and only to the selected field.
  - Sources: an aumentar-only press (up), a disminuir-only press (down), or an auto-repeat tick.
- Wrap-around:
  - Hour: 23 + 1 → 0, 0 − 1 → 23.
  - Minute and second: 59 + 1 → 0, 0 − 1 → 59.
  - All arithmetic is modulo the field range; no carry into other fields.
- Simultaneous events:
  - aumentar and disminuir both high: no step, and the repeat counter clears.
  - funct_select press in the same cycle as a step or repeat tick: the transition wins and the step is dropped.
- Auto-repeat:
  - Repeat counter clears on a press and counts while exactly one of aumentar/disminuir stays high.
  - At count REPEAT_DELAY, one step fires; thereafter one step fires every REPEAT_RATE cycles.
  - Releasing the button clears the counter.
- Timeout:
  - Counter clears on any press, any repeat tick, and any state entry; it counts in config states.
  - At TIMEOUT it goes to IDLE without write_strobe (abort). Outputs keep the edited values; field = 0.
- In IDLE: inc/dec and the repeat/timeout counters are inert (held at 0).

## Timing
- Reset values:
  - hour_out = min_out = sec_out = 0, field = 0.
  - config_active = 0, write_strobe = 0.
  - State IDLE; all counters and prev registers 0.
- Press latency: the output changes on the first rising edge that samples the new input level high.
- Snapshot: captured on the same edge as IDLE→SET_HOUR, so field = 1 and config_active = 1 from that edge.
- Commit: write_strobe is high for exactly the one cycle following the SET_SEC→IDLE edge. hour/min/sec_out are stable during that cycle and stay stable until the next snapshot.
- Auto-repeat timing:
  - First repeat step lands REPEAT_DELAY edges after the press edge.
  - Subsequent steps are spaced REPEAT_RATE edges apart.
- Reset mid-operation:
  - Asserting reset in any state returns to IDLE immediately and clears every output and counter.
  - No write_strobe is emitted.

## Test plan
- funct_select ×1 with hour_in = 22, min_in = 5, sec_in = 7 → field = 1, config_active = 1, hour_out = 22, min_out = 5, sec_out = 7 on the press edge.
- In SET_HOUR, two aumentar presses from 22 → hour_out = 23, then 0. In SET_MIN, disminuir at 0 → min_out = 59.
- With REPEAT_DELAY = 4, REPEAT_RATE = 2, hold aumentar 10 cycles in SET_SEC from 10 → sec_out steps to 11 (press), 12 (cycle 4), 13 (cycle 6), 14 (cycle 8), 15 (cycle 10).
- funct_select ×4 with edits → IDLE, write_strobe high exactly 1 cycle, field = 0, outputs hold the edited values.
- With TIMEOUT = 8, enter SET_MIN and idle 8 cycles → IDLE, config_active = 0, write_strobe never asserted.
- aumentar and disminuir pressed together → no change. funct_select plus aumentar in the same cycle → field advances, value unchanged. reset low in SET_MIN → all outputs 0 immediately.
